fp_mul_seq: RTL and testbench

Sequential IEEE-754 single-precision multiplier that sits directly upstream of the combinational float adder and supplies products for multiply-add chains. Operands are accepted over a valid/ready handshake. The 24×24 mantissa product is built by a one-bit-per-cycle shift-add loop, then normalized and packed. The result is held under valid/ready backpressure. Denormals are flushed to zero, matching the adder's normal-only datapath.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_mant_mul_seq.sv | 44 ++++
 rtl/fp_mul_seq.sv | 165 ++++++++++++++++
 tb/tb_fp_mul_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants, IEEE-754 single field helpers and FSM state type for the
// sequential float multiplier.
package fp_pkg;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [EXP_W-1:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [MANT_W-2:0] fp_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp_mant_mul_seq.sv
// Iterative 24x24 shift-add mantissa multiplier: one multiplier bit per cycle,
// 48-bit accumulator; `last` is high in the cycle whose edge adds the final bit.
module fp_mant_mul_seq
    import fp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MANT_W-1:0]     mcand,
    input  logic [MANT_W-1:0]     mplier,
    output logic                  last,
    output logic [2*MANT_W-1:0]   acc
);

    logic [MANT_W-1:0] mcand_r;
    logic [MANT_W-1:0] mplier_r;
    logic [4:0]        count;
    logic              busy;

    assign last = busy && (count == 5'(MANT_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            count    <= '0;
            busy     <= 1'b0;
            acc      <= '0;
        end else if (start) begin
            mcand_r  <= mcand;
            mplier_r <= mplier;
            count    <= '0;
            busy     <= 1'b1;
            acc      <= '0;
        end else if (busy) begin
            if (mplier_r[count])
                acc <= acc + ({{MANT_W{1'b0}}, mcand_r} << count);
            count <= count + 5'd1;
            if (last)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single multiplier (denormals flushed to zero).
// Define FP_MUL_RNE_EN for round-to-nearest-even; default build truncates.
module fp_mul_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // in_ready is high only in IDLE, out_valid only in DONE, and result/ovf/unf
    // hold steady while out_valid is high and out_ready is low.

    localparam logic signed [9:0] EXP_BIAS = 10'(BIAS);

    state_t state, state_nxt;

    logic                  accept, special, mul_start, mul_last;
    logic [31:0]           spec_res;
    logic [2*MANT_W-1:0]   acc;
    logic                  sign_r, spec_r;
    logic [31:0]           spec_res_r;
    logic signed [9:0]     exp_r, exp_n;
    logic [MANT_W-2:0]     mant_n;
    logic [31:0]           res_n;
    logic                  ovf_n, unf_n;

    logic [EXP_W-1:0] ea, eb;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_in;

    assign ea      = fp_exp(op_a);
    assign eb      = fp_exp(op_b);
    assign sign_in = fp_sign(op_a) ^ fp_sign(op_b);
    assign a_nan   = (ea == 8'hFF) && (fp_frac(op_a) != '0);
    assign b_nan   = (eb == 8'hFF) && (fp_frac(op_b) != '0);
    assign a_inf   = (ea == 8'hFF) && (fp_frac(op_a) == '0);
    assign b_inf   = (eb == 8'hFF) && (fp_frac(op_b) == '0);
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);

    always_comb begin
        special  = 1'b1;
        spec_res = QNAN;
        if (a_nan || b_nan)
            spec_res = QNAN;
        else if ((a_inf && b_zero) || (b_inf && a_zero))
            spec_res = QNAN;
        else if (a_inf || b_inf)
            spec_res = {sign_in, 8'hFF, 23'b0};
        else if (a_zero || b_zero)
            spec_res = {sign_in, 31'b0};
        else
            special = 1'b0;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Specials skip MUL but still pass through NORM so they are packed by
    // the same output register, one cycle after acceptance.
    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                state_nxt = special ? NORM : MUL;
                mul_start = !special;
            end
            MUL:  if (mul_last) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    fp_mant_mul_seq u_mant (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .mcand  ({1'b1, fp_frac(op_a)}),
        .mplier ({1'b1, fp_frac(op_b)}),
        .last   (mul_last),
        .acc    (acc)
    );

`ifdef FP_MUL_RNE_EN
    logic [MANT_W-2:0] mant_sel;
    logic [MANT_W-1:0] mant_rnd;
    logic              guard, sticky, round_up;

    always_comb begin
        mant_sel = acc[47] ? acc[46:24] : acc[45:23];
        guard    = acc[47] ? acc[23] : acc[22];
        sticky   = acc[47] ? (|acc[22:0]) : (|acc[21:0]);
        round_up = guard && (sticky || mant_sel[0]);
        mant_rnd = {1'b0, mant_sel} + {{(MANT_W-1){1'b0}}, round_up};
        mant_n   = mant_rnd[MANT_W-2:0];
        // A carry out of the fraction leaves it zero and bumps the exponent.
        exp_n    = exp_r + (acc[47] ? 10'sd1 : 10'sd0) + (mant_rnd[MANT_W-1] ? 10'sd1 : 10'sd0);
    end
`else
    logic trunc_unused;
    assign trunc_unused = |acc[22:0];

    always_comb begin
        mant_n = acc[47] ? acc[46:24] : acc[45:23];
        exp_n  = exp_r + (acc[47] ? 10'sd1 : 10'sd0);
    end
`endif

    always_comb begin
        ovf_n = 1'b0;
        unf_n = 1'b0;
        res_n = {sign_r, exp_n[7:0], mant_n};
        if (spec_r) begin
            res_n = spec_res_r;
        end else if (exp_n >= 10'sd255) begin
            res_n = {sign_r, 8'hFF, 23'b0};
            ovf_n = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            res_n = {sign_r, 31'b0};
            unf_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r     <= 1'b0;
            spec_r     <= 1'b0;
            spec_res_r <= '0;
            exp_r      <= '0;
            result     <= '0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
        end else begin
            if (accept) begin
                sign_r     <= sign_in;
                spec_r     <= special;
                spec_res_r <= spec_res;
                exp_r      <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - EXP_BIAS;
            end
            if (state == NORM) begin
                result <= res_n;
                ovf    <= ovf_n;
                unf    <= unf_n;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed self-checking bench for fp_mul_seq with hand-computed products.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        ovf;
    logic        unf;

    int n_checks = 0;
    int n_errors = 0;

    logic [33:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    fp_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic o, input logic u, input int lat);
        exp_q.push_back({o, u, res});
        lat_q.push_back(lat);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = $urandom_range(32'h7FFF_FFFF, 0);
        op_b     = $urandom_range(32'h7FFF_FFFF, 0);
    endtask

    task automatic receive(input int hold, input string tag);
        logic [33:0] e;
        int          lat;
        int          exp_lat;
        e       = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        lat     = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, e[31:0]);
        check({tag, "_ovf"}, 32'(ovf), 32'(e[33]));
        check({tag, "_unf"}, 32'(unf), 32'(e[32]));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op_a     = 32'h3F80_0000;
            op_b     = 32'h3F80_0000;
            @(posedge clk);
            #1;
            check({tag, "_hold_res"}, result, e[31:0]);
            check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_done_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_done_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic o, input logic u, input int lat);
        send(a, b, res, o, u, lat);
        receive(0, tag);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_unf", 32'(unf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("two_x_three", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 25);
        run_op("neg_two_x_three", 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 1'b0, 1'b0, 25);
        run_op("one_x_one", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 25);
        run_op("norm47", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, 25);
`ifdef FP_MUL_RNE_EN
        run_op("tie", 32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 1'b0, 1'b0, 25);
`else
        run_op("tie", 32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0001, 1'b0, 1'b0, 25);
`endif
        run_op("ovf", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0, 25);
        run_op("max_exp", 32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 1'b0, 1'b0, 25);
        run_op("unf", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1, 25);
        run_op("min_norm", 32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 1'b0, 1'b0, 25);
        run_op("unf_edge", 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 25);
        run_op("zero_x_neg", 32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
        run_op("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1);
        run_op("inf_x_neg", 32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1'b0, 1'b0, 1);
        run_op("nan", 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1);
        run_op("denorm", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0, 1);

        send(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 25);
        receive(10, "backpressure");

        // Abort a multiply partway through MUL with an asynchronous reset.
        send(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, 25);
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_unf", 32'(unf), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        run_op("after_abort", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0, 25);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
